// File: rtl/ble_remote_comm.sv
// Host-side remote link: sends 16-bit commands as two 8N1 bytes (high, low) and
// receives single-byte responses on an independent 8N1 receiver.
module ble_remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_rx_rdy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  cmd_state_t    cstate, cstate_nxt;
  logic [7:0]    cmd_lo;
  logic          tx_launch, tx_busy, tx_done;
  logic [7:0]    tx_byte;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  // High byte goes straight into the shifter on send_cmd, so only the low byte is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cstate   <= C_IDLE;
      cmd_lo   <= '0;
      cmd_sent <= 1'b0;
    end else begin
      cstate <= cstate_nxt;
      if (cstate == C_IDLE && send_cmd) begin
        cmd_lo   <= cmd[7:0];
        cmd_sent <= 1'b0;
      end else if (cstate == C_LOW && tx_done) begin
        cmd_sent <= 1'b1;
      end
    end
  end

  always_comb begin
    cstate_nxt = cstate;
    tx_launch  = 1'b0;
    tx_byte    = cmd_lo;
    case (cstate)
      C_IDLE: if (send_cmd) begin
        tx_launch  = 1'b1;
        tx_byte    = cmd[15:8];
        cstate_nxt = C_HIGH;
      end
      C_HIGH: if (tx_done) cstate_nxt = C_LOW;
      C_LOW: begin
        if (tx_done) cstate_nxt = C_IDLE;
        else if (!tx_busy) tx_launch = 1'b1;
      end
      default: cstate_nxt = C_IDLE;
    endcase
  end

  assign tx_done = tx_busy && tx_cnt == FULL && tx_bit == 4'd9;

  // tx_bit 0 is the start bit; tx_sh holds the remaining data bits plus stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      TX      <= 1'b1;
    end else if (tx_launch) begin
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= {1'b1, tx_byte};
      TX      <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == FULL) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          TX      <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          TX     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  rx_state_t     rstate, rstate_nxt;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          start_ok, rx_complete;

  always_comb begin
    rstate_nxt  = rstate;
    start_ok    = 1'b0;
    rx_complete = 1'b0;
    case (rstate)
      R_IDLE:  if (rx_d && !rx_s2) rstate_nxt = R_START;
      R_START: if (rx_cnt == HALF) begin
        if (rx_s2) rstate_nxt = R_IDLE;
        else begin
          rstate_nxt = R_DATA;
          start_ok   = 1'b1;
        end
      end
      R_DATA:  if (rx_cnt == FULL && rx_bit == 3'd7) rstate_nxt = R_STOP;
      R_STOP:  if (rx_cnt == FULL) begin
        rstate_nxt  = R_IDLE;
        rx_complete = 1'b1;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rstate   <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      rx_s1  <= RX;
      rx_s2  <= rx_s1;
      rx_d   <= rx_s2;
      rstate <= rstate_nxt;
      if (rstate == R_IDLE || rstate_nxt != rstate || rx_cnt == FULL) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (start_ok) rx_bit <= '0;
      else if (rstate == R_DATA && rx_cnt == FULL) begin
        rx_bit <= rx_bit + 3'd1;
        rx_sh  <= {rx_s2, rx_sh[7:1]};
      end
      if (rx_complete) resp <= rx_sh;
      // A completing byte wins over a clear in the same cycle.
      if (rx_complete) resp_rdy <= 1'b1;
      else if (clr_rx_rdy || start_ok) resp_rdy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ble_remote_comm.sv
// Randomized bench for ble_remote_comm against a cycle-indexed line model of both UART directions.
module tb_ble_remote_comm;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n, send_cmd, cmd_sent, tx, rx_drv, loop, clr, resp_rdy;
  logic [15:0] cmd;
  logic [7:0]  resp;
  wire         rx_line = loop ? tx : rx_drv;

  ble_remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .TX(tx), .RX(rx_line), .resp(resp), .resp_rdy(resp_rdy), .clr_rx_rdy(clr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  // Model: TX waveform computed from send cycle; RX decoded from recorded line history.
  bit          hist [0:32767];
  bit          rst_q = 1'b0, m_act = 1'b0, m_sent = 1'b0, r_busy = 1'b0;
  int          m_s, r_f, k, clr_a = -1, clr_b = -1, set_c = -1;
  logic [15:0] m_cmd;
  logic [7:0]  e_resp = 8'h00, set_v, byt;
  logic        e_rdy = 1'b0, e_tx;

  initial foreach (hist[i]) hist[i] = 1'b1;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < 32768) begin
      if (!rst_q) begin
        m_act = 0; m_sent = 0; r_busy = 0; e_resp = 8'h00; e_rdy = 0;
        clr_a = -1; clr_b = -1; set_c = -1;
      end
      if (m_act && cyc == m_s + 20*B + 2) begin m_act = 0; m_sent = 1; end
      e_tx = 1'b1;
      if (m_act && cyc > m_s) begin
        k = cyc - m_s - 1;
        if (k < 10*B) e_tx = fbit(m_cmd[15:8], k / B);
        else if (k > 10*B) e_tx = fbit(m_cmd[7:0], (k - 10*B - 1) / B);
      end
      if (cyc == clr_a || cyc == clr_b) e_rdy = 1'b0;
      if (cyc == set_c) begin e_rdy = 1'b1; e_resp = set_v; end
      check("tx_line", 16'(tx), 16'(e_tx));
      check("cmd_sent", 16'(cmd_sent), 16'(m_sent));
      check("resp", 16'(resp), 16'(e_resp));
      check("resp_rdy", 16'(resp_rdy), 16'(e_rdy));
      // consume this cycle's inputs
      if (rst_n && send_cmd && !m_act) begin m_act = 1; m_s = cyc; m_cmd = cmd; m_sent = 0; end
      hist[cyc] = rst_n ? rx_line : 1'b1;
      if (rst_n) begin
        if (clr) clr_a = cyc + 1;
        if (!r_busy) begin
          if (hist[cyc-1] && !hist[cyc]) begin r_busy = 1; r_f = cyc; end
        end else if (cyc == r_f + B/2) begin
          if (hist[cyc]) r_busy = 0;
          else clr_b = cyc + 3;
        end else if (cyc == r_f + B/2 + 9*B) begin
          for (int i = 0; i < 8; i++) byt[i] = hist[r_f + B/2 + B*(i+1)];
          set_v = byt; set_c = cyc + 3; r_busy = 0;
        end
      end
    end
    rst_q = rst_n;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sends a command and decodes both bytes off TX at mid-bit; lat = cycles to cmd_sent.
  task automatic send_dec(input logic [15:0] c, output logic [7:0] hi, output logic [7:0] lo,
                          output int lat);
    int s, kk;
    hi = '0; lo = '0; lat = -1;
    cmd = c; send_cmd = 1'b1; s = cyc; tick(); send_cmd = 1'b0; cmd = 16'($urandom);
    for (int n = 0; n < 30*B; n++) begin
      kk = cyc - s - 1;
      if (kk < 10*B && kk % B == B/2 && kk/B >= 1 && kk/B <= 8) hi[kk/B-1] = tx;
      kk = kk - 10*B - 1;
      if (kk >= 0 && kk % B == B/2 && kk/B >= 1 && kk/B <= 8) lo[kk/B-1] = tx;
      if (cmd_sent) begin lat = cyc - s; break; end
      tick();
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin rx_drv = f[j]; repeat (B) tick(); end
  endtask

  task automatic wait_rdy(input logic v, input string nm);
    for (int n = 0; n < 12*B && resp_rdy !== v; n++) tick();
    check(nm, 16'(resp_rdy), 16'(v));
  endtask

  logic [7:0]  hi, lo, rb;
  logic [15:0] rc;
  int          lat;

  initial begin
    rst_n = 0; send_cmd = 0; cmd = '0; rx_drv = 1; loop = 0; clr = 0;
    tick(); tick();
    rst_n = 1;
    check("rst_tx", 16'(tx), 16'h1);
    check("rst_cmd_sent", 16'(cmd_sent), 16'h0);
    check("rst_resp_rdy", 16'(resp_rdy), 16'h0);
    check("rst_resp", 16'(resp), 16'h0);
    repeat (3) tick();

    send_dec(16'h2000, hi, lo, lat);
    check("t2_hi", 16'(hi), 16'h20);
    check("t2_lo", 16'(lo), 16'h00);
    check("t2_latency", 16'(lat), 16'(20*B + 2));
    repeat (10) tick();
    check("t2_sticky", 16'(cmd_sent), 16'h1);

    loop = 1;
    fork
      send_dec(16'hA55A, hi, lo, lat);
      begin
        wait_rdy(1'b1, "t3_rdy1");
        check("t3_byte1", 16'(resp), 16'hA5);
        wait_rdy(1'b0, "t3_rdy_drop");
        wait_rdy(1'b1, "t3_rdy2");
        check("t3_byte2", 16'(resp), 16'h5A);
      end
    join
    loop = 0;
    repeat (5) tick();

    drive_byte(8'hA5);
    repeat (2) tick();
    check("t4_resp", 16'(resp), 16'hA5);
    check("t4_rdy", 16'(resp_rdy), 16'h1);
    clr = 1; tick(); clr = 0;
    check("t4_clr", 16'(resp_rdy), 16'h0);

    rx_drv = 0; repeat (5) tick(); rx_drv = 1;
    repeat (2*B) tick();
    check("t5_glitch_rdy", 16'(resp_rdy), 16'h0);
    check("t5_glitch_resp", 16'(resp), 16'hA5);

    fork
      send_dec(16'h1234, hi, lo, lat);
      begin
        repeat (5*B) tick();
        cmd = 16'hFFFF; send_cmd = 1; tick(); send_cmd = 0;
      end
    join
    check("t6_hi", 16'(hi), 16'h12);
    check("t6_lo", 16'(lo), 16'h34);
    check("t6_latency", 16'(lat), 16'(20*B + 2));

    for (int it = 0; it < 8; it++) begin
      rc = 16'($urandom); rb = 8'($urandom);
      fork
        send_dec(rc, hi, lo, lat);
        begin repeat ($urandom_range(0, 3*B)) tick(); drive_byte(rb); end
        begin repeat ($urandom_range(0, 14*B)) tick(); clr = 1; tick(); clr = 0; end
      join
      check("rnd_hi", 16'(hi), 16'(rc[15:8]));
      check("rnd_lo", 16'(lo), 16'(rc[7:0]));
      check("rnd_rx", 16'(resp), 16'(rb));
      repeat ($urandom_range(1, 20)) tick();
    end

    cmd = 16'h0000; send_cmd = 1; tick(); send_cmd = 0;
    repeat (3*B + 3) tick();
    check("t6_pre_rst_tx", 16'(tx), 16'h0);
    rst_n = 0; tick();
    check("t6_rst_tx", 16'(tx), 16'h1);
    check("t6_rst_sent", 16'(cmd_sent), 16'h0);
    rst_n = 1;
    repeat (5) tick();
    send_dec(16'hC33C, hi, lo, lat);
    check("t6_after_hi", 16'(hi), 16'hC3);
    check("t6_after_lo", 16'(lo), 16'h3C);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
